perceptron_train_ctrl: RTL and testbench

//  Training sequencer for the perceptron datapath. Buffers labelled samples, then runs epochs:

---
 rtl/perceptron_pkg.sv | 20 ++
 rtl/perceptron_train_ctrl_if.sv | 36 +++
 rtl/perceptron_sample_buf.sv | 65 ++++++
 rtl/perceptron_train_ctrl.sv | 177 +++++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// Shared state encoding and default sizing for the perceptron training controller.
// Latency: none, types and constants only.
// Backpressure: none.
package perceptron_pkg;

  localparam int N_IN_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int EPW_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CMP,
    ST_UPD,
    ST_EPOCH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Sample stream plus datapath channels between host, controller and perceptron datapath.
// Latency: wires only.
// Backpressure: s_valid/s_ready on samples; the datapath channels are strobes with no stall.
interface perceptron_train_ctrl_if
  import perceptron_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);

  logic            s_valid;
  logic            s_ready;
  logic [N_IN-1:0] s_x;
  logic            s_label;

  logic            dp_valid;
  logic [N_IN-1:0] dp_x;
  logic            dp_class_valid;
  logic            dp_class;

  logic            wupd_valid;
  logic            wupd_inc;
  logic [N_IN-1:0] wupd_mask;

  // Environment side: host sample source and the perceptron datapath.
  modport master (
    output s_valid, s_x, s_label, dp_class_valid, dp_class,
    input  s_ready, dp_valid, dp_x, wupd_valid, wupd_inc, wupd_mask
  );

  // Controller side.
  modport slave (
    input  s_valid, s_x, s_label, dp_class_valid, dp_class,
    output s_ready, dp_valid, dp_x, wupd_valid, wupd_inc, wupd_mask
  );

endinterface

// File: rtl/perceptron_sample_buf.sv
// Labelled-sample register file: append-only writes at count, indexed combinational read.
// Latency: write visible one cycle after wr_en_i; read is combinational.
// Backpressure: full_o set at DEPTH entries; writes while full are dropped.
module perceptron_sample_buf
  import perceptron_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [N_IN-1:0] wr_x_i,
  input  logic            wr_label_i,
  input  logic            clr_i,
  input  logic [IW-1:0]   rd_idx_i,
  output logic [N_IN-1:0] rd_x_o,
  output logic            rd_label_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o
);

  logic [N_IN-1:0]  x_mem_q [DEPTH];
  logic [DEPTH-1:0] lbl_mem_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             wr_ok;

  assign full_o = (count_q == CW'(DEPTH));
  assign wr_ok  = wr_en_i && !full_o && !clr_i;

  // Occupancy next-state: a clear wins over a same-cycle write.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (wr_ok) begin
      count_d = count_q + CW'(1);
    end
  end

  // Occupancy register; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries at or above count_q are never read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      x_mem_q[count_q[IW-1:0]]   <= wr_x_i;
      lbl_mem_q[count_q[IW-1:0]] <= wr_label_i;
    end
  end

  assign rd_x_o     = x_mem_q[rd_idx_i];
  assign rd_label_o = lbl_mem_q[rd_idx_i];
  assign count_o    = count_q;

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: replays buffered samples per epoch, issues weight updates on misclassification.
// Latency: start to first dp_valid 1 cycle; >=3 cycles per sample (+1 with update) plus datapath latency.
// Backpressure: samples accepted only in IDLE while not full; waits indefinitely for the datapath result.
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int EPW   = EPW_DEF,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  perceptron_train_ctrl_if.slave    bus,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      clear,
  input  logic [EPW-1:0]            max_epochs,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic [EPW-1:0]            epoch_cnt,
  output logic [CW-1:0]             err_cnt
);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [EPW-1:0]  limit_q;
  logic [EPW-1:0]  epoch_q;
  logic [CW-1:0]   err_q;
  logic            conv_q;
  logic            label_q;
  logic            class_q;
  logic            dp_valid_q;
  logic [N_IN-1:0] dp_x_q;
  logic            wupd_valid_q;
  logic            wupd_inc_q;
  logic [N_IN-1:0] wupd_mask_q;

  logic [N_IN-1:0] rd_x;
  logic            rd_label;
  logic [CW-1:0]   count;
  logic            full;
  logic [IW-1:0]   rd_idx;
  logic            idle_or_done;
  logic            go;
  logic            buf_clr;
  logic            last;
  logic [EPW-1:0]  epoch_inc;
  logic [CW-1:0]   err_inc;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // abort beats start; an empty buffer makes start a no-op.
  assign go           = idle_or_done && start && !abort && (count != '0);
  // start beats clear; clear is ignored while training.
  assign buf_clr      = idle_or_done && clear && !go;
  assign bus.s_ready  = (state_q == ST_IDLE) && !full;
  assign last         = (CW'(idx_q) == count - CW'(1));
  // From CMP/UPD the next sample is idx+1; every other entry into ISSUE starts a pass at 0.
  assign rd_idx       = ((state_q == ST_CMP) || (state_q == ST_UPD)) ? idx_q + IW'(1) : '0;
  assign epoch_inc    = (epoch_q == '1) ? epoch_q : epoch_q + EPW'(1);
  assign err_inc      = (err_q == '1) ? err_q : err_q + CW'(1);

  perceptron_sample_buf #(
    .N_IN  (N_IN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (bus.s_valid && bus.s_ready),
    .wr_x_i     (bus.s_x),
    .wr_label_i (bus.s_label),
    .clr_i      (buf_clr),
    .rd_idx_i   (rd_idx),
    .rd_x_o     (rd_x),
    .rd_label_o (rd_label),
    .count_o    (count),
    .full_o     (full)
  );

  // Training FSM; strobes are set on the transition so they are high exactly while in ISSUE/UPD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      limit_q      <= '0;
      epoch_q      <= '0;
      err_q        <= '0;
      conv_q       <= 1'b0;
      label_q      <= 1'b0;
      class_q      <= 1'b0;
      dp_valid_q   <= 1'b0;
      dp_x_q       <= '0;
      wupd_valid_q <= 1'b0;
      wupd_inc_q   <= 1'b0;
      wupd_mask_q  <= '0;
    end else begin
      dp_valid_q   <= 1'b0;
      wupd_valid_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (go) begin
              state_q    <= ST_ISSUE;
              idx_q      <= '0;
              epoch_q    <= '0;
              err_q      <= '0;
              conv_q     <= 1'b0;
              limit_q    <= (max_epochs == '0) ? EPW'(1) : max_epochs;
              dp_valid_q <= 1'b1;
              dp_x_q     <= rd_x;
              label_q    <= rd_label;
            end else if ((state_q == ST_DONE) && clear) begin
              state_q <= ST_IDLE;
            end
          end
          ST_ISSUE: state_q <= ST_WAIT;
          ST_WAIT: begin
            if (bus.dp_class_valid) begin
              class_q <= bus.dp_class;
              state_q <= ST_CMP;
            end
          end
          ST_CMP, ST_UPD: begin
            if ((state_q == ST_CMP) && (class_q != label_q)) begin
              state_q      <= ST_UPD;
              err_q        <= err_inc;
              wupd_valid_q <= 1'b1;
              wupd_inc_q   <= label_q;
              wupd_mask_q  <= dp_x_q;
            end else if (last) begin
              state_q <= ST_EPOCH;
            end else begin
              state_q    <= ST_ISSUE;
              idx_q      <= idx_q + IW'(1);
              dp_valid_q <= 1'b1;
              dp_x_q     <= rd_x;
              label_q    <= rd_label;
            end
          end
          ST_EPOCH: begin
            epoch_q <= epoch_inc;
            if (err_q == '0) begin
              state_q <= ST_DONE;
              conv_q  <= 1'b1;
            end else if (epoch_inc >= limit_q) begin
              state_q <= ST_DONE;
            end else begin
              state_q    <= ST_ISSUE;
              idx_q      <= '0;
              err_q      <= '0;
              dp_valid_q <= 1'b1;
              dp_x_q     <= rd_x;
              label_q    <= rd_label;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.dp_valid   = dp_valid_q;
  assign bus.dp_x       = dp_x_q;
  assign bus.wupd_valid = wupd_valid_q;
  assign bus.wupd_inc   = wupd_inc_q;
  assign bus.wupd_mask  = wupd_mask_q;
  assign busy           = !idle_or_done;
  assign done           = (state_q == ST_DONE);
  assign converged      = conv_q;
  assign epoch_cnt      = epoch_q;
  assign err_cnt        = err_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Bench for perceptron_train_ctrl: load table, directed training scenarios, randomized runs vs epoch model.
// Latency: n/a.
// Backpressure: the datapath responder answers 1..3 cycles after each dp_valid.
module tb_perceptron_train_ctrl;

  localparam int N_IN  = 16;
  localparam int DEPTH = 8;
  localparam int EPW   = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, abort, clear;
  logic [EPW-1:0] max_epochs;
  logic           busy, done, converged;
  logic [EPW-1:0] epoch_cnt;
  logic [3:0]     err_cnt;

  perceptron_train_ctrl_if #(.N_IN(N_IN)) bif ();

  perceptron_train_ctrl #(.N_IN(N_IN), .DEPTH(DEPTH), .EPW(EPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .start      (start),
    .abort      (abort),
    .clear      (clear),
    .max_epochs (max_epochs),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .epoch_cnt  (epoch_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N_IN-1:0] smp_x [DEPTH];
  logic            smp_lbl [DEPTH];
  bit              wrong_tbl [16][DEPTH];
  int              run_n = 1;
  int              resp_k = 0;
  bit              resp_en = 1'b1;

  logic [N_IN-1:0] got_dp [$];
  logic [N_IN:0]   got_upd [$];
  logic [N_IN-1:0] exp_dp [$];
  logic [N_IN:0]   exp_upd [$];
  int              exp_epoch, exp_err;
  bit              exp_conv;

  typedef struct {
    logic            sv;
    logic [N_IN-1:0] x;
    logic            lbl;
    logic            clr;
    logic            st;
    logic            exp_rdy;
    logic            exp_busy;
  } vec_t;
  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: record every strobe the controller produces.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bif.dp_valid) got_dp.push_back(bif.dp_x);
      if (bif.wupd_valid) got_upd.push_back({bif.wupd_inc, bif.wupd_mask});
    end
  end

  // Datapath stand-in: the k-th presentation of a run is sample k%n of epoch k/n.
  initial begin : responder
    logic [N_IN-1:0] cap;
    int e, i;
    bif.dp_class_valid = 1'b0;
    bif.dp_class       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.dp_valid && resp_en) begin
        cap = bif.dp_x;
        e = resp_k / run_n;
        i = resp_k % run_n;
        resp_k++;
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        chk("dp_x_hold", 32'(bif.dp_x), 32'(cap));
        bif.dp_class       = smp_lbl[i] ^ ((e < 16) ? wrong_tbl[e][i] : 1'b1);
        bif.dp_class_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.dp_class_valid = 1'b0;
      end
    end
  end

  // Reference: whole epochs over the sample list, stopping on a clean epoch or at the limit.
  task automatic model_run(input int n, input int lim);
    int e_lim, errs;
    e_lim = (lim == 0) ? 1 : lim;
    exp_dp.delete();
    exp_upd.delete();
    exp_conv = 1'b0;
    for (int e = 0; e < 16; e++) begin
      errs = 0;
      for (int i = 0; i < n; i++) begin
        exp_dp.push_back(smp_x[i]);
        if (wrong_tbl[e][i]) begin
          errs++;
          exp_upd.push_back({smp_lbl[i], smp_x[i]});
        end
      end
      exp_epoch = e + 1;
      exp_err   = errs;
      if (errs == 0) begin
        exp_conv = 1'b1;
        break;
      end
      if (e + 1 >= e_lim) break;
    end
  endtask

  task automatic set_wrong(input int mode);
    for (int e = 0; e < 16; e++)
      for (int i = 0; i < DEPTH; i++)
        case (mode)
          0:       wrong_tbl[e][i] = 1'b0;
          1:       wrong_tbl[e][i] = (e == 0) && (i == 1);
          2:       wrong_tbl[e][i] = 1'b1;
          default: wrong_tbl[e][i] = ($urandom_range(0, 3) == 0);
        endcase
  endtask

  task automatic rand_samples(input int n);
    for (int i = 0; i < n; i++) begin
      smp_x[i]   = 16'($urandom);
      smp_lbl[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_to_idle", 32'(busy | done), 32'(0));
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      bif.s_valid = 1'b1;
      bif.s_x     = smp_x[i];
      bif.s_label = smp_lbl[i];
      step();
    end
    bif.s_valid = 1'b0;
  endtask

  task automatic run_train(input int n, input int lim, input bit with_clear);
    got_dp.delete();
    got_upd.delete();
    resp_k = 0;
    run_n  = n;
    model_run(n, lim);
    max_epochs = EPW'(lim);
    start      = 1'b1;
    clear      = with_clear;
    step();
    start = 1'b0;
    clear = 1'b0;
    chk("start_latency", 32'(bif.dp_valid), 32'(1));
    for (int c = 0; c < 4000; c++) begin
      if (done) break;
      step();
    end
    chk("done", 32'(done), 32'(1));
    chk("busy_after", 32'(busy), 32'(0));
    chk("dp_count", 32'(got_dp.size()), 32'(exp_dp.size()));
    for (int j = 0; j < exp_dp.size() && j < got_dp.size(); j++)
      chk("dp_x", 32'(got_dp[j]), 32'(exp_dp[j]));
    chk("upd_count", 32'(got_upd.size()), 32'(exp_upd.size()));
    for (int j = 0; j < exp_upd.size() && j < got_upd.size(); j++)
      chk("upd_inc_mask", 32'(got_upd[j]), 32'(exp_upd[j]));
    chk("converged", 32'(converged), 32'(exp_conv));
    chk("epoch_cnt", 32'(epoch_cnt), 32'(exp_epoch));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    int tb_cnt, n, lim;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; clear = 1'b0; max_epochs = '0;
    bif.s_valid = 1'b0; bif.s_x = '0; bif.s_label = 1'b0;
    set_wrong(0);
    step();
    step();
    chk("rst_s_ready", 32'(bif.s_ready), 32'(1));
    chk("rst_dp_valid", 32'(bif.dp_valid), 32'(0));
    chk("rst_wupd_valid", 32'(bif.wupd_valid), 32'(0));
    chk("rst_status", 32'({busy, done, converged}), 32'(0));
    chk("rst_counts", 32'({epoch_cnt, err_cnt}), 32'(0));
    rst_n = 1'b1;
    step();

    // Load table: empty start ignored, 8 stored, 9th refused.
    vec[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{1'b1, 16'hA001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 16'h5A02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 16'h0F03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{1'b1, 16'hF004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 16'h3305, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 16'hCC06, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 16'h1207, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b1, 16'h8808, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tb_cnt = 0;
    for (int r = 0; r < 11; r++) begin
      if (vec[r].clr) tb_cnt = 0;
      if (vec[r].sv && tb_cnt < DEPTH) begin
        smp_x[tb_cnt]   = vec[r].x;
        smp_lbl[tb_cnt] = vec[r].lbl;
        tb_cnt++;
      end
      bif.s_valid = vec[r].sv; bif.s_x = vec[r].x; bif.s_label = vec[r].lbl;
      clear = vec[r].clr; start = vec[r].st; max_epochs = EPW'(1);
      step();
      bif.s_valid = 1'b0; clear = 1'b0; start = 1'b0;
      chk("tbl_s_ready", 32'(bif.s_ready), 32'(vec[r].exp_rdy));
      chk("tbl_busy", 32'(busy), 32'(vec[r].exp_busy));
    end
    // Full buffer, start together with clear: start wins and all 8 are replayed.
    run_train(8, 1, 1'b1);

    // Two samples, datapath always right.
    clear_buf(); rand_samples(2); load(2); set_wrong(0);
    run_train(2, 5, 1'b0);

    // Wrong only on sample 1 of the first epoch, label 1.
    clear_buf(); rand_samples(2); smp_lbl[1] = 1'b1; load(2); set_wrong(1);
    run_train(2, 5, 1'b0);

    // Always wrong, limit 3.
    clear_buf(); rand_samples(4); load(4); set_wrong(2);
    run_train(4, 3, 1'b0);

    // max_epochs=0 and empty buffer: start ignored; then one sample gives one epoch.
    clear_buf();
    max_epochs = '0; start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_start_busy", 32'(busy), 32'(0));
    chk("empty_start_dp", 32'(bif.dp_valid), 32'(0));
    rand_samples(1); load(1); set_wrong(2);
    run_train(1, 0, 1'b0);

    // Abort while waiting for the datapath.
    clear_buf(); rand_samples(3); load(3);
    resp_en = 1'b0;
    got_dp.delete(); got_upd.delete();
    max_epochs = EPW'(4); start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("wait_busy", 32'(busy), 32'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 32'({busy, done, bif.s_ready}), 32'(1));
    repeat (10) step();
    chk("abort_dp_quiet", 32'(got_dp.size()), 32'(1));
    chk("abort_upd_quiet", 32'(got_upd.size()), 32'(0));
    resp_en = 1'b1;
    set_wrong(3);
    run_train(3, 2, 1'b0);

    // Randomized runs; some re-run straight from DONE on the same buffer.
    n = 3;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        clear_buf();
        n = $urandom_range(1, DEPTH);
        rand_samples(n);
        load(n);
      end
      set_wrong(3);
      lim = $urandom_range(0, 5);
      run_train(n, lim, 1'($urandom_range(0, 1)));
    end

    // Synchronous reset mid-run empties the buffer.
    clear_buf(); rand_samples(2); load(2);
    resp_en = 1'b0;
    max_epochs = EPW'(2); start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("midrst_status", 32'({busy, done, bif.dp_valid}), 32'(0));
    chk("midrst_s_ready", 32'(bif.s_ready), 32'(1));
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("midrst_buffer_empty", 32'(busy), 32'(0));
    resp_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
